// File: rtl/pipe_perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package pipe_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perf_state_e;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_CYCLE_LIMIT = 30;

  // Largest value a counter of the given width can hold, widened to 64 bits.
  function automatic logic [63:0] sat_max(input int width);
    if (width >= 64) return '1;
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/pipe_perf_sat_cnt.sv
// Saturating event counter: increments on inc_i, sticks at all-ones, clears on clr_i.
module pipe_perf_sat_cnt
  import pipe_perf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] nxt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  // nxt_o lets the parent capture the final count on the same edge it is made.
  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: run/stall/flush/retire counters with snapshot/ack.
// Define PERF_HIST_EN to add the retire-PC history buffer and its read port.
module pipe_perf_monitor
  import pipe_perf_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT,
  parameter int PC_W        = 32,
  parameter int HIST_DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [PC_W-1:0]  retire_pc_i,
  input  logic             clr_i,
  input  logic             snap_req_i,
  output logic             snap_ack_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             running_o,
  output logic             done_o
`ifdef PERF_HIST_EN
  ,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx_i,
  output logic [PC_W-1:0]               hist_pc_o
`endif
);

  localparam logic [63:0] LIMIT = 64'(CYCLE_LIMIT);
  // A limit the cycle counter can never reach disables auto-stop entirely.
  localparam bit LIMIT_ON = (CYCLE_LIMIT != 0) && (LIMIT <= sat_max(CNT_W));

  perf_state_e state_q, state_d;
  logic        in_run, limit_hit;
  logic [CNT_W-1:0] cyc_q, stl_q, fls_q, ret_q;
  logic [CNT_W-1:0] cyc_n, stl_n, fls_n, ret_n;
  logic [CNT_W-1:0] cyc_snap_q, stl_snap_q, fls_snap_q, ret_snap_q;
  logic snap_ack_q, running_q, done_q;

  assign in_run    = (state_q == ST_RUN);
  assign limit_hit = LIMIT_ON && in_run && (64'(cyc_q) == LIMIT - 64'd1);

  pipe_perf_sat_cnt #(.CNT_W(CNT_W)) u_cyc (.clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .inc_i(in_run), .cnt_o(cyc_q), .nxt_o(cyc_n));
  pipe_perf_sat_cnt #(.CNT_W(CNT_W)) u_stl (.clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .inc_i(in_run && stall_i), .cnt_o(stl_q), .nxt_o(stl_n));
  pipe_perf_sat_cnt #(.CNT_W(CNT_W)) u_fls (.clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .inc_i(in_run && flush_i), .cnt_o(fls_q), .nxt_o(fls_n));
  pipe_perf_sat_cnt #(.CNT_W(CNT_W)) u_ret (.clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .inc_i(in_run && retire_i), .cnt_o(ret_q), .nxt_o(ret_n));

  // Reaching the limit wins over start_i dropping on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (limit_hit)     state_d = ST_DONE;
        else if (!start_i) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      snap_ack_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      cyc_snap_q <= '0;
      stl_snap_q <= '0;
      fls_snap_q <= '0;
      ret_snap_q <= '0;
    end else if (clr_i) begin
      state_q    <= ST_IDLE;
      snap_ack_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      cyc_snap_q <= '0;
      stl_snap_q <= '0;
      fls_snap_q <= '0;
      ret_snap_q <= '0;
    end else begin
      state_q    <= state_d;
      snap_ack_q <= snap_req_i || limit_hit;
      running_q  <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
      // The auto snapshot on DONE entry includes the final cycle's increments.
      if (limit_hit) begin
        cyc_snap_q <= cyc_n;
        stl_snap_q <= stl_n;
        fls_snap_q <= fls_n;
        ret_snap_q <= ret_n;
      end else if (snap_req_i) begin
        cyc_snap_q <= cyc_q;
        stl_snap_q <= stl_q;
        fls_snap_q <= fls_q;
        ret_snap_q <= ret_q;
      end
    end
  end

  assign snap_ack_o   = snap_ack_q;
  assign running_o    = running_q;
  assign done_o       = done_q;
  assign cycle_cnt_o  = cyc_snap_q;
  assign stall_cnt_o  = stl_snap_q;
  assign flush_cnt_o  = fls_snap_q;
  assign retire_cnt_o = ret_snap_q;

`ifdef PERF_HIST_EN
  localparam int HIW = $clog2(HIST_DEPTH);

  logic [PC_W-1:0] hist_q [HIST_DEPTH];
  logic [HIW-1:0]  wr_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      wr_ptr_q <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      wr_ptr_q <= '0;
    end else if (in_run && retire_i) begin
      hist_q[wr_ptr_q] <= retire_pc_i;
      wr_ptr_q         <= wr_ptr_q + HIW'(1);
    end
  end

  // wr_ptr_q points at the next free slot, so the newest entry sits one below it.
  assign hist_pc_o = hist_q[wr_ptr_q - HIW'(1) - hist_idx_i];
`else
  logic unused_hist;
  assign unused_hist = ^retire_pc_i;
`endif

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: default instance plus a 4-bit, no-limit instance.
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stall = 1'b0, flush = 1'b0, retire = 1'b0;
  logic [31:0] pc = '0;
  logic        clr = 1'b0, snap = 1'b0;
  logic        ack, running, done;
  logic [31:0] cyc_o, stl_o, fls_o, ret_o;

  logic        start4 = 1'b0, snap4 = 1'b0;
  logic        ack4, running4, done4;
  logic [3:0]  cyc4, stl4, fls4, ret4;

  int checks = 0;
  int errors = 0;

`ifdef PERF_HIST_EN
  logic [1:0]  hidx = '0, hidx4 = '0;
  logic [31:0] hpc, hpc4;
`endif

  always #5 clk = ~clk;

  pipe_perf_monitor u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .retire_i(retire), .retire_pc_i(pc), .clr_i(clr), .snap_req_i(snap),
    .snap_ack_o(ack), .cycle_cnt_o(cyc_o), .stall_cnt_o(stl_o), .flush_cnt_o(fls_o),
    .retire_cnt_o(ret_o), .running_o(running), .done_o(done)
`ifdef PERF_HIST_EN
    , .hist_idx_i(hidx), .hist_pc_o(hpc)
`endif
  );

  pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .stall_i(1'b0), .flush_i(1'b0),
    .retire_i(1'b0), .retire_pc_i(32'h0), .clr_i(1'b0), .snap_req_i(snap4),
    .snap_ack_o(ack4), .cycle_cnt_o(cyc4), .stall_cnt_o(stl4), .flush_cnt_o(fls4),
    .retire_cnt_o(ret4), .running_o(running4), .done_o(done4)
`ifdef PERF_HIST_EN
    , .hist_idx_i(hidx4), .hist_pc_o(hpc4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_snap(input string tag, input int c, input int s, input int f, input int r);
    chk({tag, "_cycle"},  64'(cyc_o), 64'(c));
    chk({tag, "_stall"},  64'(stl_o), 64'(s));
    chk({tag, "_flush"},  64'(fls_o), 64'(f));
    chk({tag, "_retire"}, 64'(ret_o), 64'(r));
  endtask

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_snap("rst", 0, 0, 0, 0);
    chk("rst_ack", 64'(ack), 0);
    chk("rst_running", 64'(running), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst4_cycle", 64'(cyc4), 0);

    // Run to the 30-cycle limit
    start = 1'b1;
    tick();
    chk("t1_running", 64'(running), 1);
    for (int i = 0; i < 30; i++) begin
      stall  = (i < 2);
      flush  = (i == 2);
      retire = (i >= 3 && i < 23);
      if (i == 29) begin
        chk("t1_pre_ack", 64'(ack), 0);
        chk("t1_pre_done", 64'(done), 0);
      end
      tick();
    end
    stall = 1'b0; flush = 1'b0; retire = 1'b0;
    chk("t1_done", 64'(done), 1);
    chk("t1_running_off", 64'(running), 0);
    chk("t1_ack", 64'(ack), 1);
    chk_snap("t1", 30, 2, 1, 20);
    tick();
    chk("t1_ack_once", 64'(ack), 0);
    chk("t1_done_hold", 64'(done), 1);
    chk("t1_cycle_hold", 64'(cyc_o), 30);

    // clr together with a snapshot request in DONE
    start = 1'b0; clr = 1'b1; snap = 1'b1;
    tick();
    clr = 1'b0; snap = 1'b0;
    chk_snap("t5", 0, 0, 0, 0);
    chk("t5_ack", 64'(ack), 0);
    chk("t5_done", 64'(done), 0);
    chk("t5_running", 64'(running), 0);
    tick();
    chk("t5_ack_after", 64'(ack), 0);
    chk("t5_idle", 64'(running), 0);

    // Simultaneous stall and flush, then held snapshot request
    start = 1'b1;
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    tick();
    snap = 1'b1;
    tick();
    chk("t2_ack", 64'(ack), 1);
    chk_snap("t2", 2, 1, 1, 0);
    tick();
    chk("t2_ack_held", 64'(ack), 1);
    chk("t2_cycle_held", 64'(cyc_o), 3);
    snap = 1'b0;
    tick();
    chk("t2_ack_drop", 64'(ack), 0);
    chk("t2_cycle_kept", 64'(cyc_o), 3);

    // Pause for 3 cycles, resume, then 5 retires
    start = 1'b0;
    tick();
    chk("t4_paused", 64'(running), 0);
    tick(); tick();
    start = 1'b1;
    tick();
    chk("t4_resumed", 64'(running), 1);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("t4_cycle", 64'(cyc_o), 6);
    retire = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      pc = 32'h1000 + 32'(4 * k);
      tick();
    end
    retire = 1'b0;
`ifdef PERF_HIST_EN
    hidx = 2'd0; #1 chk("t6_hist0", 64'(hpc), 64'h1014);
    hidx = 2'd1; #1 chk("t6_hist1", 64'(hpc), 64'h1010);
    hidx = 2'd3; #1 chk("t6_hist3", 64'(hpc), 64'h1008);
`endif
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk_snap("t4b", 12, 1, 1, 5);

    // Asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    chk_snap("t6", 0, 0, 0, 0);
    chk("t6_ack", 64'(ack), 0);
    chk("t6_running", 64'(running), 0);
    chk("t6_done", 64'(done), 0);
`ifdef PERF_HIST_EN
    for (int j = 0; j < 4; j++) begin
      hidx = 2'(j);
      #1 chk("t6_hist_zero", 64'(hpc), 0);
    end
`endif
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_ack_after", 64'(ack), 0);
    chk("t6_cycle_after", 64'(cyc_o), 0);

    // 4-bit counter saturation with no auto-stop
    start4 = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    chk("t3_pre_ack", 64'(ack4), 0);
    snap4 = 1'b1;
    tick();
    snap4 = 1'b0;
    chk("t3_cycle_sat", 64'(cyc4), 15);
    chk("t3_running", 64'(running4), 1);
    chk("t3_ack", 64'(ack4), 1);
    chk("t3_done", 64'(done4), 0);
    tick();
    chk("t3_ack_once", 64'(ack4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
